// File: rtl/fifo_level.sv
// Synchronous FIFO with registered level count, programmable almost-full/empty
// thresholds and overflow/underflow pulses. Define FIFO_LEVEL_FWFT_EN for first-word-fall-through.
module fifo_level #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  rd_accept;
    logic                  wr_accept;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_CNT);
    assign almost_empty = (int'(count_q) <= AE_LEVEL);
    assign almost_full  = (int'(count_q) >= AF_LEVEL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write into a full FIFO is allowed when a read frees the slot on the same edge.
    assign rd_accept = !rst && rd_en && !empty;
    assign wr_accept = !rst && wr_en && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= wr_en && !wr_accept;
            underflow_q <= rd_en && !rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_accept && !rd_accept) begin
                count_q <= count_q + CNT_ONE;
            end else if (rd_accept && !wr_accept) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

`ifdef FIFO_LEVEL_FWFT_EN
    // Head word is shown combinationally; forced to zero while empty so reset reads as 0.
    assign data_out   = empty ? '0 : mem[rd_ptr];
    assign data_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= rd_accept;
            if (rd_accept) begin
                data_out_q <= mem[rd_ptr];
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
`endif

endmodule
